// File: rtl/approx_mult_pkg.sv
// Shared constants and helpers for the pipelined approximate multiplier.
// Tiles are 4x4 nibble products; level selects how many low product bits are cleared.
package approx_mult_pkg;

    localparam int unsigned TILE_W = 4;

    typedef enum logic [1:0] {
        LVL_EXACT = 2'd0,
        LVL_T1    = 2'd1,
        LVL_T2    = 2'd2,
        LVL_T3    = 2'd3
    } lvl_e;

    function automatic int unsigned n_tiles(input int unsigned width);
        return (width / TILE_W) * (width / TILE_W);
    endfunction

endpackage

// File: rtl/approx_tile_4x4.sv
// Combinational 4x4 unsigned tile product with run-time truncation of its low bits.
module approx_tile_4x4
    import approx_mult_pkg::*;
(
    input  logic [TILE_W-1:0]   a,
    input  logic [TILE_W-1:0]   b,
    input  logic [1:0]          lvl,
    output logic [2*TILE_W-1:0] p
);

    logic [2*TILE_W-1:0] prod;
    logic [2*TILE_W-1:0] keep;

    always_comb begin
        prod = a * b;
        keep = '1;
        unique case (lvl_e'(lvl))
            LVL_EXACT: keep = 8'hFF;
            LVL_T1:    keep = 8'hFE;
            LVL_T2:    keep = 8'hFC;
            LVL_T3:    keep = 8'hF8;
            default:   keep = '1;
        endcase
        p = prod & keep;
    end

endmodule

// File: rtl/approx_mult_pipe.sv
// Three-stage stallable approximate multiplier: S1 beat register, S2 tile products,
// S3 exact or OR-approximate combine. Valid/ready on both sides, bubbles collapse.
module approx_mult_pipe
    import approx_mult_pkg::*;
#(
    parameter int unsigned WIDTH   = 8,
    parameter int unsigned ADD_APX = 4
) (
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic                                 in_valid,
    output logic                                 in_ready,
    input  logic [WIDTH-1:0]                     in_a,
    input  logic [WIDTH-1:0]                     in_b,
    input  logic [2*(2*(WIDTH/TILE_W)-1)-1:0]    in_lvl,
    input  logic                                 in_add_apx,
    output logic                                 out_valid,
    input  logic                                 out_ready,
    output logic [2*WIDTH-1:0]                   out_r
);

    localparam int unsigned N    = WIDTH / TILE_W;
    localparam int unsigned NT   = n_tiles(WIDTH);
    localparam int unsigned LVLW = 2 * (2 * N - 1);
    localparam int unsigned RW   = 2 * WIDTH;
    localparam int unsigned PW   = 2 * TILE_W;

    logic                   v1_q, v1_d, v2_q, v2_d, v3_q, v3_d;
    logic [WIDTH-1:0]       a1_q, a1_d, b1_q, b1_d;
    logic [LVLW-1:0]        lvl1_q, lvl1_d;
    logic                   apx1_q, apx1_d, apx2_q, apx2_d;
    logic [NT-1:0][PW-1:0]  tile_p;
    logic [NT-1:0][PW-1:0]  tile2_q, tile2_d;
    logic [RW-1:0]          r3_q, r3_d;

    logic                   ld1, ld2, ld3, out_fire;
    logic [RW-1:0]          sh, sum_exact, or_all, sum_hi, low_mask, combined;

    for (genvar gi = 0; gi < N; gi++) begin : g_row
        for (genvar gj = 0; gj < N; gj++) begin : g_col
            approx_tile_4x4 u_tile (
                .a   (a1_q[TILE_W*gi +: TILE_W]),
                .b   (b1_q[TILE_W*gj +: TILE_W]),
                .lvl (lvl1_q[2*(gi+gj) +: 2]),
                .p   (tile_p[gi*N+gj])
            );
        end
    end

    // Each stage loads when empty or when its current content moves on this cycle.
    always_comb begin
        out_fire = v3_q && out_ready;
        ld3      = v2_q && (!v3_q || out_ready);
        ld2      = v1_q && (!v2_q || ld3);
        in_ready = !v1_q || ld2;
        ld1      = in_valid && in_ready;
    end

    // Approximate mode: no carry crosses from the OR-ed low field into the upper sum.
    always_comb begin
        sum_exact = '0;
        or_all    = '0;
        sum_hi    = '0;
        low_mask  = '0;
        sh        = '0;
        for (int unsigned k = 0; k < RW; k++) begin
            low_mask[k] = (k < ADD_APX);
        end
        for (int unsigned i = 0; i < N; i++) begin
            for (int unsigned j = 0; j < N; j++) begin
                sh        = RW'(tile2_q[i*N+j]) << (TILE_W * (i + j));
                sum_exact = sum_exact + sh;
                or_all    = or_all | sh;
                sum_hi    = sum_hi + (sh >> ADD_APX);
            end
        end
        combined = apx2_q ? ((sum_hi << ADD_APX) | (or_all & low_mask)) : sum_exact;
    end

    always_comb begin
        v1_d    = ld1 ? 1'b1 : (ld2 ? 1'b0 : v1_q);
        a1_d    = ld1 ? in_a : a1_q;
        b1_d    = ld1 ? in_b : b1_q;
        lvl1_d  = ld1 ? in_lvl : lvl1_q;
        apx1_d  = ld1 ? in_add_apx : apx1_q;

        v2_d    = ld2 ? 1'b1 : (ld3 ? 1'b0 : v2_q);
        tile2_d = ld2 ? tile_p : tile2_q;
        apx2_d  = ld2 ? apx1_q : apx2_q;

        v3_d    = ld3 ? 1'b1 : (out_fire ? 1'b0 : v3_q);
        r3_d    = ld3 ? combined : r3_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            v1_q <= 1'b0;
            v2_q <= 1'b0;
            v3_q <= 1'b0;
            r3_q <= '0;
        end else begin
            v1_q <= v1_d;
            v2_q <= v2_d;
            v3_q <= v3_d;
            r3_q <= r3_d;
        end
        a1_q    <= a1_d;
        b1_q    <= b1_d;
        lvl1_q  <= lvl1_d;
        apx1_q  <= apx1_d;
        tile2_q <= tile2_d;
        apx2_q  <= apx2_d;
    end

    assign out_valid = v3_q;
    assign out_r     = r3_q;

endmodule

// File: tb/tb_approx_mult_pipe.sv
// Bench for approx_mult_pipe: directed WIDTH=8 vectors plus a WIDTH=16 random sweep,
// all results checked against an arithmetic reference model through a FIFO scoreboard.
`timescale 1ns/1ps
module tb_approx_mult_pipe;

    localparam int W8 = 8, K8 = 6, W16 = 16, K16 = 5;

    logic clk, rst;

    logic        in_valid8, in_ready8, in_apx8, out_valid8, out_ready8;
    logic [7:0]  in_a8, in_b8;
    logic [5:0]  in_lvl8;
    logic [15:0] out_r8;

    logic        in_valid16, in_ready16, in_apx16, out_valid16, out_ready16;
    logic [15:0] in_a16, in_b16;
    logic [13:0] in_lvl16;
    logic [31:0] out_r16;

    int n_cmp = 0;
    int n_err = 0;
    int bp_sent;
    logic [63:0] q8[$];
    logic [63:0] q16[$];

    approx_mult_pipe #(.WIDTH(W8), .ADD_APX(K8)) u_dut8 (
        .clk(clk), .rst(rst),
        .in_valid(in_valid8), .in_ready(in_ready8),
        .in_a(in_a8), .in_b(in_b8), .in_lvl(in_lvl8), .in_add_apx(in_apx8),
        .out_valid(out_valid8), .out_ready(out_ready8), .out_r(out_r8)
    );

    approx_mult_pipe #(.WIDTH(W16), .ADD_APX(K16)) u_dut16 (
        .clk(clk), .rst(rst),
        .in_valid(in_valid16), .in_ready(in_ready16),
        .in_a(in_a16), .in_b(in_b16), .in_lvl(in_lvl16), .in_add_apx(in_apx16),
        .out_valid(out_valid16), .out_ready(out_ready16), .out_r(out_r16)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Reference: per nibble-pair products, truncated by modulo, weighted by powers of 16.
    function automatic logic [63:0] model(input int w, input int k, input logic [31:0] a,
                                          input logic [31:0] b, input logic [13:0] lvl,
                                          input logic apx);
        logic [63:0] exact, lo, hi, t;
        int n, lv;
        n = w / 4;
        exact = 0; lo = 0; hi = 0;
        for (int i = 0; i < n; i++) begin
            for (int j = 0; j < n; j++) begin
                t  = 64'((a >> (4*i)) & 32'hF) * 64'((b >> (4*j)) & 32'hF);
                lv = int'((lvl >> (2*(i+j))) & 14'h3);
                t  = t - (t % (64'd1 << lv));
                t  = t * (64'd1 << (4*(i+j)));
                exact = exact + t;
                lo    = lo | t;
                hi    = hi + (t >> k);
            end
        end
        if (!apx) return exact;
        return (hi << k) + (lo % (64'd1 << k));
    endfunction

    // Scoreboard: every presented result must equal the oldest outstanding expectation.
    always @(negedge clk) begin
        if (rst) begin
            q8.delete();
            q16.delete();
        end else begin
            if (out_valid8) begin
                if (q8.size() == 0) check("dut8_spurious_valid", 64'(out_valid8), 64'd0);
                else begin
                    check("dut8_result", 64'(out_r8), q8[0]);
                    if (out_ready8) void'(q8.pop_front());
                end
            end
            if (out_valid16) begin
                if (q16.size() == 0) check("dut16_spurious_valid", 64'(out_valid16), 64'd0);
                else begin
                    check("dut16_result", 64'(out_r16), q16[0]);
                    if (out_ready16) void'(q16.pop_front());
                end
            end
            if (in_valid8 && in_ready8)
                q8.push_back(model(W8, K8, 32'(in_a8), 32'(in_b8), 14'(in_lvl8), in_apx8));
            if (in_valid16 && in_ready16)
                q16.push_back(model(W16, K16, 32'(in_a16), 32'(in_b16), in_lvl16, in_apx16));
        end
    end

    task automatic send8(input logic [7:0] a, input logic [7:0] b, input logic [5:0] l,
                         input logic x);
        bit acc;
        int budget;
        in_valid8 = 1'b1; in_a8 = a; in_b8 = b; in_lvl8 = l; in_apx8 = x;
        budget = 0;
        do begin
            @(negedge clk); acc = in_ready8;
            @(posedge clk); #1; budget++;
        end while (!acc && budget < 50);
        check("send8_accept", 64'(acc), 64'd1);
        in_valid8 = 1'b0;
    endtask

    task automatic wait_res8(input string name, input logic [15:0] exp);
        int n;
        n = 0;
        do begin @(negedge clk); n++; end while (!out_valid8 && n < 20);
        check({name, "_valid"}, 64'(out_valid8), 64'd1);
        check(name, 64'(out_r8), 64'(exp));
        @(posedge clk); #1;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [15:0] held;
        bit have;
        bit acc16;
        int sent, cycles;

        rst = 1'b1;
        in_valid8 = 0; in_a8 = 0; in_b8 = 0; in_lvl8 = 0; in_apx8 = 0; out_ready8 = 1;
        in_valid16 = 0; in_a16 = 0; in_b16 = 0; in_lvl16 = 0; in_apx16 = 0; out_ready16 = 1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("rst_out_valid8", 64'(out_valid8), 64'd0);
        check("rst_out_r8", 64'(out_r8), 64'd0);
        check("rst_in_ready8", 64'(in_ready8), 64'd1);
        check("rst_out_valid16", 64'(out_valid16), 64'd0);
        check("rst_out_r16", 64'(out_r16), 64'd0);
        check("rst_in_ready16", 64'(in_ready16), 64'd1);

        check("model_exact_ff", model(8, 6, 32'hFF, 32'hFF, 14'd0, 1'b0), 64'd65025);
        check("model_trunc_0f", model(8, 6, 32'h0F, 32'h0F, 14'b000010, 1'b0), 64'd224);
        check("model_apx_on", model(8, 6, 32'h13, 32'h13, 14'd0, 1'b1), 64'd313);
        check("model_apx_off", model(8, 6, 32'h13, 32'h13, 14'd0, 1'b0), 64'd361);
        @(posedge clk); #1;

        // Exact product with three-cycle latency from the accept cycle
        send8(8'hFF, 8'hFF, 6'd0, 1'b0);
        @(negedge clk); check("lat_c1_valid", 64'(out_valid8), 64'd0);
        @(negedge clk); check("lat_c2_valid", 64'(out_valid8), 64'd0);
        @(negedge clk); check("lat_c3_valid", 64'(out_valid8), 64'd1);
        check("exact_ff", 64'(out_r8), 64'd65025);
        @(negedge clk); check("lat_c4_valid", 64'(out_valid8), 64'd0);
        @(posedge clk); #1;

        send8(8'h0F, 8'h0F, 6'b000010, 1'b0);
        wait_res8("trunc_0f", 16'd224);
        send8(8'h13, 8'h13, 6'd0, 1'b1);
        wait_res8("apx_on", 16'd313);
        send8(8'h13, 8'h13, 6'd0, 1'b0);
        wait_res8("apx_off", 16'd361);

        // Backpressure: five beats offered while the consumer stalls for six cycles
        out_ready8 = 1'b0; bp_sent = 0; have = 0; held = '0;
        fork
            begin
                for (int i = 0; i < 5; i++) begin
                    send8(8'(8'h21 + i * 8'h11), 8'(8'h3C + i), 6'(i * 5), 1'(i));
                    bp_sent++;
                end
            end
            begin
                repeat (6) begin
                    @(negedge clk);
                    if (out_valid8) begin
                        if (!have) begin held = out_r8; have = 1; end
                        else check("bp_hold_stable", 64'(out_r8), 64'(held));
                    end
                end
                check("bp_accepted_while_full", 64'(bp_sent), 64'd3);
                check("bp_in_ready_low", 64'(in_ready8), 64'd0);
                @(posedge clk); #1 out_ready8 = 1'b1;
                repeat (5) begin
                    @(negedge clk);
                    check("bp_stream_valid", 64'(out_valid8), 64'd1);
                end
            end
        join
        @(posedge clk); #1;

        // Reset with three beats in flight
        out_ready8 = 1'b0;
        send8(8'hA5, 8'h5A, 6'd0, 1'b0);
        send8(8'h77, 8'h99, 6'd0, 1'b1);
        send8(8'hC3, 8'h3C, 6'd0, 1'b0);
        rst = 1'b1;
        @(posedge clk); #1 rst = 1'b0; out_ready8 = 1'b1;
        @(negedge clk);
        check("midrst_out_valid", 64'(out_valid8), 64'd0);
        check("midrst_out_r", 64'(out_r8), 64'd0);
        check("midrst_in_ready", 64'(in_ready8), 64'd1);
        repeat (6) begin
            @(negedge clk);
            check("midrst_no_ghost", 64'(out_valid8), 64'd0);
        end
        @(posedge clk); #1;
        check("dut8_queue_empty", 64'(q8.size()), 64'd0);

        // Random sweep on the 16-bit instance
        sent = 0; cycles = 0; acc16 = 0;
        while (sent < 10000 && cycles < 60000) begin
            if (!in_valid16 || acc16) begin
                in_valid16 = ($urandom_range(3) != 0);
                in_a16     = 16'($urandom);
                in_b16     = 16'($urandom);
                in_lvl16   = 14'($urandom);
                in_apx16   = 1'($urandom);
            end
            out_ready16 = ($urandom_range(3) != 0);
            @(negedge clk);
            acc16 = in_valid16 && in_ready16;
            if (acc16) sent++;
            @(posedge clk); #1;
            cycles++;
        end
        in_valid16 = 1'b0; out_ready16 = 1'b1;
        check("sweep_sent", 64'(sent), 64'd10000);
        cycles = 0;
        while (q16.size() != 0 && cycles < 50) begin
            @(posedge clk); #1; cycles++;
        end
        check("sweep_drained", 64'(q16.size()), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
